// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the single-cycle SCC core.
// Owns the PC and reads instruction memory. B, Bcond, BR and HALT are
// resolved here. Every other word goes to the decoder through a registered
// valid/ready IF->ID register. A taken or not-taken branch costs one bubble,
// because branch words are never forwarded to the decoder.
module instr_fetch #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    output logic [2:0]          br_reg_addr,
    input  logic [31:0]         br_reg_data,
    input  logic [3:0]          flags,
    input  logic                resume,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                halted,
    output logic                branch_taken
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [6:0]          OP_B     = 7'b1100000;
    localparam logic [6:0]          OP_BCOND = 7'b1100001;
    localparam logic [6:0]          OP_BR    = 7'b1100010;
    localparam logic [6:0]          OP_HALT  = 7'b1101000;
    localparam logic [31:0]         NOP_WORD = 32'hC800_0000;
    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);

    // Architectural state
    state_t              state_q,        state_d;
    logic [PC_WIDTH-1:0] pc_q,           pc_d;
    logic                if_valid_q,     if_valid_d;
    logic [31:0]         if_instr_q,     if_instr_d;
    logic [PC_WIDTH-1:0] if_pc_q,        if_pc_d;
    logic                branch_taken_q, branch_taken_d;

    // Decode of the word currently on imem_data
    logic [6:0]          op;
    logic [3:0]          cond_sel;
    logic [31:0]         off_ext;
    logic [PC_WIDTH-1:0] off;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_rel;
    logic                cond_true;
    logic                advance;

    // Flag aliases, in the order the ALU packs them
    logic flag_n, flag_z, flag_c, flag_v;

    assign op       = imem_data[31:25];
    assign cond_sel = imem_data[24:21];
    // The offset is relative to the branch's own pc, and the sum wraps at PC_WIDTH.
    assign off_ext  = {{16{imem_data[15]}}, imem_data[15:0]};
    assign off      = off_ext[PC_WIDTH-1:0];
    assign pc_inc   = pc_q + PC_ONE;
    assign pc_rel   = pc_q + off;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // The fetch slot moves when running and the IF->ID register is empty or draining.
    assign advance = (state_q == ST_RUN) && (!if_valid_q || id_ready);

    // Unused instruction fields and the upper register bits (a PC is only PC_WIDTH wide)
    logic unused_bits;
    assign unused_bits = ^{imem_data[20:16], br_reg_data, off_ext};

    // Evaluate the Bcond condition code against the flags of the fetch cycle
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cond_true = 1'b0;
        unique case (cond_sel)
            4'h0: cond_true = flag_z;
            4'h1: cond_true = !flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = !flag_c;
            4'h4: cond_true = flag_n;
            4'h5: cond_true = !flag_n;
            4'h6: cond_true = flag_v;
            4'h7: cond_true = !flag_v;
            4'h8: cond_true = flag_c && !flag_z;
            4'h9: cond_true = !flag_c || flag_z;
            4'hA: cond_true = (flag_n == flag_v);
            4'hB: cond_true = (flag_n != flag_v);
            4'hC: cond_true = !flag_z && (flag_n == flag_v);
            4'hD: cond_true = flag_z || (flag_n != flag_v);
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-state logic: PC redirect, IF->ID register load, and RUN/HALTED control
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        if_valid_d     = if_valid_q;
        if_instr_d     = if_instr_q;
        if_pc_d        = if_pc_q;
        branch_taken_d = branch_taken_q;

        if (state_q == ST_HALTED) begin
            // The HALT word stays visible until the decoder takes it, and then it is gone.
            if (if_valid_q && id_ready) begin
                if_valid_d = 1'b0;
            end
            if (resume) begin
                pc_d    = pc_inc;
                state_d = ST_RUN;
            end
        end else if (advance) begin
            branch_taken_d = 1'b0;
            unique case (op)
                OP_B: begin
                    pc_d           = pc_rel;
                    if_valid_d     = 1'b0;
                    branch_taken_d = 1'b1;
                end
                OP_BCOND: begin
                    pc_d           = cond_true ? pc_rel : pc_inc;
                    if_valid_d     = 1'b0;
                    branch_taken_d = cond_true;
                end
                OP_BR: begin
                    pc_d           = br_reg_data[PC_WIDTH-1:0];
                    if_valid_d     = 1'b0;
                    branch_taken_d = 1'b1;
                end
                OP_HALT: begin
                    // The decoder still sees HALT. The pc stays on it so resume continues at pc+1.
                    if_instr_d = imem_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    state_d    = ST_HALTED;
                end
                default: begin
                    if_instr_d = imem_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_inc;
                end
            endcase
        end
    end

    // State registers; reset drops any in-flight instruction immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            if_valid_q     <= 1'b0;
            if_instr_q     <= NOP_WORD;
            if_pc_q        <= '0;
            branch_taken_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q        <= state_d;
            pc_q           <= pc_d;
            if_valid_q     <= if_valid_d;
            if_instr_q     <= if_instr_d;
            if_pc_q        <= if_pc_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign imem_addr    = pc_q;
    assign br_reg_addr  = imem_data[24:22];
    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_pc        = if_pc_q;
    assign halted       = (state_q == ST_HALTED);
    assign branch_taken = branch_taken_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed program through the fetch stage, with scoreboard queues.
// The stimulus loads the expected decoder transfers, the pc trace and the branch
// targets into queues. A negedge monitor pops and compares whenever the DUT shows an event.
module tb_instr_fetch;

    localparam logic [31:0] NOP_W  = 32'hC800_0000;
    localparam logic [31:0] HALT_W = 32'hD000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [2:0]  br_reg_addr;
    logic [31:0] br_reg_data;
    logic [3:0]  flags = 4'b0000;
    logic        resume;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;
    logic        branch_taken;

    logic [31:0] imem [0:65535];
    logic [31:0] regs [0:7];

    // imem[4] becomes an ADD after the first B there. imem[0] becomes HALT in the final phase.
    logic b4_patched  = 1'b0;
    logic final_phase = 1'b0;
    logic mon_en      = 1'b0;
    int   visit5      = 0;
    logic [15:0] prev_pc = 16'h0000;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_pcs[$];
    logic [15:0] exp_xpc[$];
    logic [31:0] exp_xin[$];
    logic [15:0] exp_bt[$];

    function automatic logic [31:0] add_w(input logic [15:0] a);
        return 32'h00A0_0000 | {16'h0000, a};
    endfunction

    assign imem_data = (imem_addr == 16'h0004 && b4_patched)  ? add_w(16'h0004) :
                       (imem_addr == 16'h0000 && final_phase) ? HALT_W : imem[imem_addr];
    assign br_reg_data = regs[br_reg_addr];

    instr_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .br_reg_addr  (br_reg_addr),
        .br_reg_data  (br_reg_data),
        .flags        (flags),
        .resume       (resume),
        .id_ready     (id_ready),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .halted       (halted),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event, value %h, nothing queued", name, act);
    endtask

    // Monitor: pc trace, decoder transfers, branch pulses; also drives flags per fetch address
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_addr != prev_pc) begin
                if (exp_pcs.size() == 0) unexpected("pc_trace", {16'h0, imem_addr});
                else check("pc_trace", {16'h0, imem_addr}, {16'h0, exp_pcs.pop_front()});
                prev_pc = imem_addr;
            end
            if (if_valid && id_ready) begin
                if (exp_xpc.size() == 0) begin
                    unexpected("xfer", if_instr);
                end else begin
                    check("xfer_pc", {16'h0, if_pc}, {16'h0, exp_xpc.pop_front()});
                    check("xfer_instr", if_instr, exp_xin.pop_front());
                end
            end
            if (branch_taken) begin
                if (exp_bt.size() == 0) unexpected("branch_taken", {16'h0, imem_addr});
                else check("branch_target", {16'h0, imem_addr}, {16'h0, exp_bt.pop_front()});
                if (imem_addr == 16'h0002) b4_patched = 1'b1;
            end
            if (imem_addr == 16'h0008) check("br_reg_addr", {29'h0, br_reg_addr}, 32'd3);
            case (imem_addr)
                16'h0005: begin
                    flags = (visit5 == 0) ? 4'b0000 : 4'b0100;
                    visit5++;
                end
                16'h0042: flags = 4'b1000;  // LT: N!=V -> taken
                16'h0044: flags = 4'b0110;  // HI: C&!Z false -> not taken
                16'h0045: flags = 4'b0001;  // LE: N!=V -> taken
                default:  flags = 4'b0000;
            endcase
        end
    end

    task automatic wait_for_addr(input logic [15:0] a, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (imem_addr == a) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, {31'h0, found}, 32'd1);
    endtask

    task automatic wait_for_halt(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (halted) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, {31'h0, found}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pcs [21] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0002,
                                  16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0005,
                                  16'h0015, 16'h0008, 16'h0040, 16'h0041, 16'h0042,
                                  16'h0044, 16'h0045, 16'h0010, 16'h0011, 16'hFFFF,
                                  16'h0000};
        logic [15:0] bts [8] = '{16'h0002, 16'h0005, 16'h0015, 16'h0008,
                                 16'h0040, 16'h0044, 16'h0010, 16'hFFFF};
        logic [15:0] xpcs [12] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0002, 16'h0003,
                                   16'h0004, 16'h0040, 16'h0041, 16'h0010, 16'hFFFF, 16'h0000};

        rst      = 1'b1;
        id_ready = 1'b1;
        resume   = 1'b0;

        for (int i = 0; i < 65536; i++) imem[i] = NOP_W;
        for (int i = 0; i < 8; i++) regs[i] = 32'hDEAD_0000 + i;
        regs[3] = 32'h0000_0040;
        for (int i = 0; i < 4; i++) imem[i] = add_w(16'(i));
        imem[16'h0004] = 32'hC000_FFFE;  // B -2     -> 2
        imem[16'h0005] = 32'hC200_0010;  // Bcond EQ -> 0x15 or 6
        imem[16'h0006] = 32'hC000_FFFF;  // B -1     -> 5
        imem[16'h0008] = 32'hC4C0_0000;  // BR r3    -> 0x40
        imem[16'h0010] = HALT_W;
        imem[16'h0011] = 32'hC000_FFEE;  // B        -> 0xFFFF
        imem[16'h0015] = 32'hC000_FFF3;  // B -13    -> 8
        imem[16'h0040] = add_w(16'h0040);
        imem[16'h0041] = add_w(16'h0041);
        imem[16'h0042] = 32'hC360_0002;  // Bcond LT +2 -> 0x44
        imem[16'h0043] = add_w(16'h0043);
        imem[16'h0044] = 32'hC300_0003;  // Bcond HI (not taken) -> 0x45
        imem[16'h0045] = 32'hC3A0_FFCB;  // Bcond LE -> 0x10
        imem[16'hFFFF] = add_w(16'hFFFF);

        foreach (pcs[i]) exp_pcs.push_back(pcs[i]);
        foreach (bts[i]) exp_bt.push_back(bts[i]);
        foreach (xpcs[i]) exp_xpc.push_back(xpcs[i]);
        exp_xin = '{add_w(16'h0000), add_w(16'h0001), add_w(16'h0002), add_w(16'h0003),
                    add_w(16'h0002), add_w(16'h0003), add_w(16'h0004), add_w(16'h0040),
                    add_w(16'h0041), HALT_W, add_w(16'hFFFF), HALT_W};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
        check("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check("rst_if_instr", if_instr, NOP_W);
        check("rst_if_pc", {16'h0, if_pc}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_branch_taken", {31'h0, branch_taken}, 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Stall for three cycles with a valid word held; resume in RUN must be ignored
        wait_for_addr(16'h0041, "reach_0x41");
        id_ready = 1'b0;
        resume   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_if_valid", {31'h0, if_valid}, 32'd1);
            check("stall_if_pc", {16'h0, if_pc}, 32'h0040);
            check("stall_if_instr", if_instr, add_w(16'h0040));
            check("stall_imem_addr", {16'h0, imem_addr}, 32'h0041);
            @(posedge clk); #1;
        end
        id_ready = 1'b1;
        resume   = 1'b0;

        // HALT at 0x10: pc frozen, handed over once, then resume
        wait_for_halt("reach_halt");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("halt_imem_addr", {16'h0, imem_addr}, 32'h0010);
            check("halt_halted", {31'h0, halted}, 32'd1);
            check("halt_if_valid", {31'h0, if_valid}, 32'd0);
        end
        final_phase = 1'b1;
        resume      = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        check("resume_imem_addr", {16'h0, imem_addr}, 32'h0011);
        check("resume_halted", {31'h0, halted}, 32'd0);

        // Wrap from 0xFFFF to 0, where HALT waits
        wait_for_halt("reach_final_halt");
        repeat (3) @(posedge clk);
        #1;
        check("final_imem_addr", {16'h0, imem_addr}, 32'h0);
        check("final_if_valid", {31'h0, if_valid}, 32'd0);
        check("final_halted", {31'h0, halted}, 32'd1);
        mon_en = 1'b0;
        check("left_pc_trace", exp_pcs.size(), 32'd0);
        check("left_xfers", exp_xpc.size(), 32'd0);
        check("left_branches", exp_bt.size(), 32'd0);

        // Asynchronous reset while halted
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst2_halted", {31'h0, halted}, 32'd0);
        check("rst2_if_instr", if_instr, NOP_W);
        check("rst2_if_valid", {31'h0, if_valid}, 32'd0);
        check("rst2_imem_addr", {16'h0, imem_addr}, 32'h0);
        check("rst2_branch_taken", {31'h0, branch_taken}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
